// File: rtl/snn_pkg.sv
// Shared types and defaults for the spike dispatch path.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAD,
    ST_DONE
  } state_e;

  localparam int unsigned DWID_DEF     = 32;
  localparam int unsigned CNTWID_DEF   = 16;
  localparam logic [31:0] PAD_WORD_DEF = '0;

endpackage

// File: rtl/dispatch_slot.sv
// One-entry valid/ready output register feeding a single synaptic core.
module dispatch_slot
  import snn_pkg::*;
#(
  parameter int unsigned DWID = DWID_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [DWID-1:0] load_data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [DWID-1:0] data_o,
  output logic            free_o
);

  logic            valid_q;
  logic [DWID-1:0] data_q;

  // Free when empty or draining this cycle, so load and drain can coincide.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/spike_dispatcher.sv
// Deals a timestep-framed spike stream alternately to two cores, padding core 1 on odd counts.
module spike_dispatcher
  import snn_pkg::*;
#(
  parameter int unsigned     DWID     = DWID_DEF,
  parameter int unsigned     CNTWID   = CNTWID_DEF,
  parameter logic [DWID-1:0] PAD_WORD = DWID'(PAD_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWID-1:0]   in_data,
  input  logic              in_last,
  output logic              ipt0_valid,
  input  logic              ipt0_ready,
  output logic [DWID-1:0]   sparse_bits0,
  output logic              ipt1_valid,
  input  logic              ipt1_ready,
  output logic [DWID-1:0]   sparse_bits1,
  output logic              step_done,
  output logic [CNTWID-1:0] step_words,
  output logic              busy
);

  state_e            state_q;
  logic              tgt_q;
  logic [CNTWID-1:0] cnt_q;
  logic [CNTWID-1:0] cnt_d;
  logic              step_done_q;
  logic [CNTWID-1:0] step_words_q;

  logic            free0, free1;
  logic            accept;
  logic            load0, load1;
  logic [DWID-1:0] load1_data;
  logic            pad_load;

  assign in_ready = rst_n && (state_q == ST_RUN) && (tgt_q ? free1 : free0);
  assign accept   = in_valid && in_ready;
  assign pad_load = (state_q == ST_PAD) && free1;

  assign load0      = accept && !tgt_q;
  assign load1      = (accept && tgt_q) || pad_load;
  assign load1_data = pad_load ? PAD_WORD : in_data;

  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNTWID'(1);

  dispatch_slot #(.DWID(DWID)) u_slot0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load0),
    .load_data_i (in_data),
    .ready_i     (ipt0_ready),
    .valid_o     (ipt0_valid),
    .data_o      (sparse_bits0),
    .free_o      (free0)
  );

  dispatch_slot #(.DWID(DWID)) u_slot1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load1),
    .load_data_i (load1_data),
    .ready_i     (ipt1_ready),
    .valid_o     (ipt1_valid),
    .data_o      (sparse_bits1),
    .free_o      (free1)
  );

  // step_done/step_words are registered on entry to DONE so the pulse is
  // visible exactly during the DONE cycle, one cycle after the final load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      tgt_q        <= 1'b0;
      cnt_q        <= '0;
      step_done_q  <= 1'b0;
      step_words_q <= '0;
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            tgt_q <= ~tgt_q;
            cnt_q <= cnt_d;
            if (in_last) begin
              if (!tgt_q) begin
                state_q <= ST_PAD;
              end else begin
                state_q      <= ST_DONE;
                step_done_q  <= 1'b1;
                step_words_q <= cnt_d;
              end
            end
          end
        end
        ST_PAD: begin
          if (free1) begin
            state_q      <= ST_DONE;
            step_done_q  <= 1'b1;
            step_words_q <= cnt_q;
          end
        end
        ST_DONE: begin
          cnt_q   <= '0;
          tgt_q   <= 1'b0;
          state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign step_done  = step_done_q;
  assign step_words = step_words_q;
  assign busy       = (cnt_q != '0) || (state_q != ST_RUN) || ipt0_valid || ipt1_valid;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Scoreboard bench for spike_dispatcher with a narrow counter to reach saturation.
module tb_spike_dispatcher;

  localparam int          CW   = 4;
  localparam int          SATV = 15;
  localparam logic [31:0] PADW = 32'h0;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_last;
  logic [31:0]   in_data;
  logic          ipt0_valid, ipt0_ready, ipt1_valid, ipt1_ready;
  logic [31:0]   sparse_bits0, sparse_bits1;
  logic          step_done, busy;
  logic [CW-1:0] step_words;

  spike_dispatcher #(.DWID(32), .CNTWID(CW), .PAD_WORD(PADW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .ipt0_valid   (ipt0_valid),
    .ipt0_ready   (ipt0_ready),
    .sparse_bits0 (sparse_bits0),
    .ipt1_valid   (ipt1_valid),
    .ipt1_ready   (ipt1_ready),
    .sparse_bits1 (sparse_bits1),
    .step_done    (step_done),
    .step_words   (step_words),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          qs[$];

  int rmode = 0;  // 0: both ready, 1: random, 2: driven directly
  int hold1 = 0;  // cycles to force core 1 not ready

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    ipt0_ready = 1'b1;
    ipt1_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) begin
        ipt0_ready = 1'b1;
        ipt1_ready = 1'b1;
      end else if (rmode == 1) begin
        ipt0_ready = ($urandom_range(0, 9) < 7);
        ipt1_ready = ($urandom_range(0, 9) < 7);
      end
      if (rmode != 2 && hold1 > 0) begin
        ipt1_ready = 1'b0;
        hold1--;
      end
    end
  end

  // Monitor: pops expected words/step counts whenever the DUT presents them.
  initial begin
    logic        pv0, pv1, pr0, pr1;
    logic [31:0] pd0, pd1, e;
    int          held;
    pv0 = 0; pv1 = 0; pr0 = 0; pr1 = 0; pd0 = 0; pd1 = 0; held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv0 = 0; pv1 = 0; held = 0;
      end else begin
        if (pv0 && !pr0) begin
          chk("hold_valid0", 32'(ipt0_valid), 32'd1);
          chk("hold_data0", sparse_bits0, pd0);
        end
        if (pv1 && !pr1) begin
          chk("hold_valid1", 32'(ipt1_valid), 32'd1);
          chk("hold_data1", sparse_bits1, pd1);
        end
        if (ipt0_valid && ipt0_ready) begin
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL core0_extra actual=%h required=none", sparse_bits0);
          end else begin
            e = q0.pop_front();
            chk("core0_word", sparse_bits0, e);
          end
        end
        if (ipt1_valid && ipt1_ready) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL core1_extra actual=%h required=none", sparse_bits1);
          end else begin
            e = q1.pop_front();
            chk("core1_word", sparse_bits1, e);
          end
        end
        if (step_done) begin
          if (qs.size() == 0) begin
            checks++; errors++;
            $display("FAIL step_extra actual=%0d required=none", step_words);
          end else begin
            held = qs.pop_front();
            chk("step_words", 32'(step_words), 32'(held));
          end
        end else begin
          chk("step_words_held", 32'(step_words), 32'(held));
        end
        pv0 = ipt0_valid; pr0 = ipt0_ready; pd0 = sparse_bits0;
        pv1 = ipt1_valid; pr1 = ipt1_ready; pd1 = sparse_bits1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input bit last, input int k,
                           output int stalls, output bit ok);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    stalls   = 0;
    ok       = 1'b0;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      // A word for core 1 must wait while core 1 holds an undelivered word.
      if ((k % 2 == 1) && (q1.size() > 0) && !ipt1_ready)
        chk("in_ready_bp", 32'(in_ready), 32'd0);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_step(input int len, output int stalls);
    logic [31:0] d;
    int          s;
    bit          ok;
    stalls = 0;
    for (int k = 0; k < len; k++) begin
      d = $urandom;
      send_word(d, (k == len - 1), k, s, ok);
      stalls += s;
      if (ok) begin
        if (k % 2 == 0) q0.push_back(d);
        else            q1.push_back(d);
        if (k == len - 1) begin
          if (len % 2 == 1) q1.push_back(PADW);
          qs.push_back((len > SATV) ? SATV : len);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_valid0"}, 32'(ipt0_valid), 32'd0);
    chk({tag, "_valid1"}, 32'(ipt1_valid), 32'd0);
    chk({tag, "_bits0"}, sparse_bits0, 32'd0);
    chk({tag, "_bits1"}, sparse_bits1, 32'd0);
    chk({tag, "_step_done"}, 32'(step_done), 32'd0);
    chk({tag, "_step_words"}, 32'(step_words), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          st, s;
    bit          ok;
    logic [31:0] w0, w1, w2;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #3;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    send_step(4, st);
    chk("even_stalls", 32'(st), 32'd0);
    send_step(3, st);
    chk("gap_after_even", 32'(st), 32'd1);
    send_step(1, st);
    chk("gap_after_odd", 32'(st), 32'd2);
    repeat (3) @(posedge clk);
    #1;

    hold1 = 10;
    send_step(8, st);
    repeat (12) @(posedge clk);
    #1;

    hold1 = 12;
    send_step(2, st);
    send_step(1, st);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ipt1_ready) break;
      chk("pad_stall_in_ready", 32'(in_ready), 32'd0);
    end
    repeat (4) @(posedge clk);
    #1;

    rmode = 2;
    ipt0_ready = 1'b1;
    ipt1_ready = 1'b0;
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    send_word(w0, 1'b0, 0, s, ok); if (ok) q0.push_back(w0);
    send_word(w1, 1'b0, 1, s, ok); if (ok) q1.push_back(w1);
    send_word(w2, 1'b0, 2, s, ok); if (ok) q0.push_back(w2);
    ipt0_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid0", 32'(ipt0_valid), 32'd1);
    chk("pre_rst_valid1", 32'(ipt1_valid), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q0.delete(); q1.delete(); qs.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rmode = 0;
    @(posedge clk);
    #1;
    send_step(2, st);
    chk("post_rst_stalls", 32'(st), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    send_step(20, st);
    repeat (3) @(posedge clk);
    #1;

    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      send_step($urandom_range(1, 9), st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    rmode = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && qs.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_steps", 32'(qs.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spike_dispatcher.md
# spike_dispatcher

Sequencer placed in front of the dual-core synaptic array. Takes one stream of 32-bit sparse spike words, grouped into timesteps by a `last` flag, and deals them alternately to synaptic core 0 and core 1. The downstream reduce stage pairs one result from each core, so every timestep must give both cores an equal word count. When a timestep has an odd number of words, the block pads core 1 with a neutral word. It reports per-timestep completion and word count.

## Interface
- `DWID`, default 32: spike word width; matches the `sparse_bits` width of the cores.
- `CNTWID`, default 16: width of the per-timestep word counter.
- `PAD_WORD`, default 0: padding word; must produce zero contribution in a core.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: upstream word accepted when `in_valid` and `in_ready` are both high.
- `in_data` input DWID: spike word.
- `in_last` input 1: marks the final word of the timestep.
- `ipt0_valid` output 1: word valid to core 0.
- `ipt0_ready` input 1: core 0 ready.
- `sparse_bits0` output DWID: word to core 0.
- `ipt1_valid` output 1: word valid to core 1.
- `ipt1_ready` input 1: core 1 ready.
- `sparse_bits1` output DWID: word to core 1.
- `step_done` output 1: one-cycle pulse when a timestep is fully dispatched.
- `step_words` output CNTWID: number of input words in the completed timestep; excludes the pad; valid while `step_done` is high, held afterwards.
- `busy` output 1: high whenever the timestep counter is nonzero, the state is not RUN, or either output slot is valid.

## Operation
- Two output slots, one per core. Each slot is a one-entry register holding valid and data.
  - A slot is free when it is empty, or when it is valid and its core ready is high this cycle (load and drain in the same cycle is allowed).
  - Slot valid stays high and data stays stable until the core handshake completes.
- `tgt` pointer: 0 selects core 0, 1 selects core 1. Reset value 0. Toggles on every accepted input word.
- Word k of a timestep (k counted from 0) always goes to core `k mod 2`.
- `cnt` is the per-timestep word counter. It increments on each accepted word and saturates at 2^CNTWID−1 (`tgt` still toggles).
- State machine:
  - **RUN**: `in_ready` equals the free status of slot `tgt`. On an accepted word, load it into slot `tgt`.
    - If `in_last` is set and the word was accepted with `tgt`=0 (odd count), go to PAD.
    - If `in_last` is set and the word was accepted with `tgt`=1, go to DONE.
  - **PAD**: `in_ready` is 0. When slot 1 is free, load `PAD_WORD` into it and go to DONE.
  - **DONE**: `in_ready` is 0. Pulse `step_done` and register `step_words` = `cnt`. Clear `cnt`, set `tgt` to 0, return to RUN.
- Accepted word with `in_last` while `tgt`=0 and slot 1 also busy: the block enters PAD and waits there. No input is accepted until the pad has been loaded.
- A single-word timestep goes to core 0, then the pad goes to core 1; `step_words` = 1.
- Reset mid-operation: everything clears asynchronously. Words held in the slots are dropped, not replayed.

## Timing
- Latency: a word accepted in cycle t appears on `sparse_bits0` or `sparse_bits1` with valid high in cycle t+1.
- Throughput: one word per cycle while both cores are ready. A stalled core blocks only the words addressed to it.
- Pad: loaded no earlier than the cycle after the last word is accepted.
- `step_done`: fires one cycle after the final load (last word or pad). The next timestep's first word can be accepted in the cycle after that.
- Per-timestep minimum gap: 1 dead cycle in the even case, 2 in the odd case.
- Reset values: `in_ready`=0 during reset; `ipt0_valid`=`ipt1_valid`=0; `sparse_bits0`=`sparse_bits1`=0; `step_done`=0; `step_words`=0; `busy`=0; state=RUN; `tgt`=0; `cnt`=0.
- `in_ready` is a combinational function of state, `tgt`, the slot valids and the core readys. It never depends on `in_valid`.

## Structure
- Shared package `snn_pkg`:
  - state enum (RUN, PAD, DONE);
  - default `DWID` and `CNTWID` constants;
  - `PAD_WORD` default.
- One sub-module, `dispatch_slot`: a one-entry valid/ready output register with inputs load and load_data, and output free. It is instantiated twice.
- Top level holds the FSM, `tgt`, `cnt` and the status outputs.

## Test plan
- **Even timestep, both cores ready.** Words A,B,C,D with `last` on D: A and C to core 0, B and D to core 1, one word per cycle. One `step_done` with `step_words`=4. No pad.
- **Odd timestep.** Words A,B,C with `last` on C: core 0 gets A,C. Core 1 gets B, then `PAD_WORD` (0). `step_words`=3. The next timestep's first word goes to core 0.
- **Backpressure.** Hold `ipt1_ready` low for 10 cycles mid-stream:
  - `in_ready` drops when `tgt`=1 and slot 1 is full;
  - `sparse_bits1` stays stable throughout;
  - no word is lost or duplicated; order is preserved per core.
- **Pad stall.** Single-word timestep arrives while slot 1 is full and core 1 is not ready: the FSM stays in PAD with `in_ready`=0. The pad is loaded once core 1 drains. `step_done` fires with `step_words`=1.
- **Reset mid-step.** Assert `rst_n` low after 3 accepted words with both slots valid:
  - all outputs go to their reset values immediately;
  - after release, a 2-word timestep dispatches normally starting at core 0.
- **Counter saturation.** With `CNTWID`=4, send 20 words then `last`: `step_words`=15. Alternation continues correctly and core 0 and core 1 each receive 10 words.
